toy_ldq_mem_responder: RTL and testbench
========================================

// Module: toy_ldq_mem_responder
// PURPOSE
//   Memory-side responder for the LDQ branch-tagged load protocol. Accepts load requests tagged with a
//   branch epoch id, queues them in order, issues them to a fixed-latency SRAM read port, and returns
//   mem_ack_* with the request's branch id and index unchanged. Queued requests whose epoch is stale
//   are discarded before issue and never acked. Epoch filtering of acks already in flight stays downstream.
// PARAMETERS
//   BRANCH_WIDTH  3   width of branch epoch id (epoch 0 never current; wraps max->1)
//   ADDR_WIDTH    32  load address width
//   DATA_WIDTH    32  read data width
//   IDX_WIDTH     4   LDQ entry index carried with request, echoed on ack
//   DEPTH         4   request FIFO entries (power of 2, >=2)
//   MEM_LAT       2   SRAM read latency in cycles (>=1)
// PORTS
//   clk                input   1             clock
//   rst_n              input   1             async active-low reset
//   req_vld            input   1             load request valid
//   req_rdy            output  1             request accepted when req_vld&req_rdy
//   req_addr           input   ADDR_WIDTH    load address
//   req_branch_id      input   BRANCH_WIDTH  epoch tag of request
//   req_idx            input   IDX_WIDTH     LDQ index of request
//   cur_branch_id      input   BRANCH_WIDTH  current epoch (from branch filter req_branch_id_nxt)
//   mem_rd_en          output  1             SRAM read strobe
//   mem_rd_addr        output  ADDR_WIDTH    SRAM read address
//   mem_rd_data        input   DATA_WIDTH    SRAM data, valid MEM_LAT cycles after mem_rd_en
//   mem_ack_vld        output  1             load ack valid (no backpressure)
//   mem_ack_branch_id  output  BRANCH_WIDTH  echoed req_branch_id
//   mem_ack_idx        output  IDX_WIDTH     echoed req_idx
//   mem_ack_data       output  DATA_WIDTH    mem_rd_data of issued read
//   occupancy          output  $clog2(DEPTH)+1  FIFO entries held
// BEHAVIOUR
//   - Reset: FIFO rd/wr pointers (with wrap bit) =0, occupancy=0, latency-pipe valids=0, mem_rd_en=0,
//     mem_ack_vld=0; all ack sideband/data =0. Reset mid-operation discards queued and in-flight loads
//     with no ack.
//   - req_rdy = (occupancy != DEPTH); registered-state only, no credit for same-cycle pop. Push when full
//     is impossible.
//   - No bypass: a request pushed in cycle T is at head at T+1 at the earliest.
//   - Every cycle FIFO not empty: pop head. Head epoch == cur_branch_id -> issue: mem_rd_en=1,
//     mem_rd_addr=head addr (combinational from head), push {branch_id,idx} into MEM_LAT-deep pipe.
//     Mismatch -> drop: pop, mem_rd_en=0, no ack. Epoch 0 always mismatches.
//   - Same-cycle push and pop: occupancy unchanged, both pointers advance, wrap via pointer MSB.
//   - Ack: a read issued in cycle I has mem_ack_vld=1 in cycle I+MEM_LAT, with mem_ack_data=mem_rd_data
//     (pass-through) and tag from pipe stage MEM_LAT. Min latency accept->ack = 1+MEM_LAT.
//   - Acks are strictly in issue order, at most one per cycle, and throughput is 1 per cycle.
//   - In-flight reads are never cancelled here: an epoch change after issue still yields an ack with the
//     old branch id. The downstream filter suppresses it.
//   - cur_branch_id is sampled at the pop cycle only. An epoch change while an entry waits is seen on the
//     entry's pop cycle.
// TESTING
//   1 Reset then req addr=0x100 br=1 idx=3 at T0, cur=1, MEM_LAT=2 -> mem_rd_en@T1 addr 0x100,
//     ack@T3 br=1 idx=3 data=SRAM[0x100].
//   2 Back-to-back 6 reqs, cur=1, DEPTH=4 -> req_rdy low only when occupancy=4; 6 acks in order,
//     1/cycle, no loss.
//   3 Queue 3 reqs br=2 with head stalled behind full pipe timing, then cur 2->3 before pop ->
//     all 3 dropped, mem_rd_en never set, occupancy->0, no acks.
//   4 Issue br=7 with cur=7, then cur 7->1 next cycle -> ack still returns br=7 at I+MEM_LAT.
//   5 rst_n low while 2 queued + 2 in flight -> mem_ack_vld stays 0 after reset, occupancy=0,
//     req_rdy=1 at first cycle after release.
//   6 Simultaneous push/pop at occupancy=DEPTH-1 for 2*DEPTH cycles -> occupancy stays, pointer wrap clean.

Source files
------------

// File: rtl/toy_ldq_mem_responder.sv
// In-order load request FIFO feeding a fixed-latency SRAM read port.
// Requests carry a branch epoch tag; stale-epoch heads are dropped at pop.
module toy_ldq_mem_responder #(
  parameter int BRANCH_WIDTH = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int IDX_WIDTH    = 4,
  parameter int DEPTH        = 4,
  parameter int MEM_LAT      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [BRANCH_WIDTH-1:0]    req_branch_id,
  input  logic [IDX_WIDTH-1:0]       req_idx,
  input  logic [BRANCH_WIDTH-1:0]    cur_branch_id,
  output logic                       mem_rd_en,
  output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  output logic                       mem_ack_vld,
  output logic [BRANCH_WIDTH-1:0]    mem_ack_branch_id,
  output logic [IDX_WIDTH-1:0]       mem_ack_idx,
  output logic [DATA_WIDTH-1:0]      mem_ack_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = BRANCH_WIDTH + IDX_WIDTH;
  localparam int EW = ADDR_WIDTH + TW;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]      fifo_q [DEPTH];
  logic [EW-1:0]      fifo_d [DEPTH];
  logic [MEM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [TW-1:0]      pipe_tag_q [MEM_LAT];
  logic [TW-1:0]      pipe_tag_d [MEM_LAT];

  logic [PW-1:0]           occ;
  logic                    push, pop, issue;
  logic [EW-1:0]           head;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [BRANCH_WIDTH-1:0] head_br;
  logic [IDX_WIDTH-1:0]    head_idx;

  // Pointers carry a wrap bit, so occupancy is a plain difference.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign occupancy = occ;
  assign req_rdy   = (occ != PW'(DEPTH));
  assign push      = req_vld & req_rdy;
  assign pop       = (occ != '0);

  assign head = fifo_q[rd_ptr_q[AW-1:0]];
  assign {head_addr, head_br, head_idx} = head;

  // Epoch 0 is never current, so a zero cur_branch_id blocks every issue.
  assign issue       = pop && (head_br == cur_branch_id) && (cur_branch_id != '0);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = head_addr;

  assign mem_ack_vld = pipe_vld_q[MEM_LAT-1];
  assign {mem_ack_branch_id, mem_ack_idx} = pipe_tag_q[MEM_LAT-1];
  assign mem_ack_data = mem_ack_vld ? mem_rd_data : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) fifo_d[i] = fifo_q[i];
    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = {req_addr, req_branch_id, req_idx};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = issue;
    pipe_tag_d[0] = {head_br, head_idx};
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_tag_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
      for (int i = 0; i < MEM_LAT; i++) pipe_tag_q[i] <= pipe_tag_d[i];
    end
  end

endmodule

// File: tb/tb_toy_ldq_mem_responder.sv
// Bench for toy_ldq_mem_responder: SRAM model, per-cycle driver with a one-entry
// head model, and an ack scoreboard keyed on expected ack cycle.
module tb_toy_ldq_mem_responder;
  localparam int MEM_LAT = 2;
  localparam int DEPTH   = 4;

  logic        clk, rst_n;
  logic        req_vld, req_rdy;
  logic [31:0] req_addr;
  logic [2:0]  req_branch_id, cur_branch_id;
  logic [3:0]  req_idx;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_ack_vld;
  logic [2:0]  mem_ack_branch_id;
  logic [3:0]  mem_ack_idx;
  logic [31:0] mem_ack_data;
  logic [2:0]  occupancy;

  toy_ldq_mem_responder #(
    .BRANCH_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .IDX_WIDTH(4), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_branch_id(req_branch_id), .req_idx(req_idx),
    .cur_branch_id(cur_branch_id),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_ack_vld(mem_ack_vld), .mem_ack_branch_id(mem_ack_branch_id),
    .mem_ack_idx(mem_ack_idx), .mem_ack_data(mem_ack_data),
    .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data for the address presented MEM_LAT cycles earlier
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  logic [31:0] sram_pipe [MEM_LAT];
  always @(posedge clk) begin
    sram_pipe[0] <= mem_rd_addr;
    for (int i = 1; i < MEM_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign mem_rd_data = sram_word(sram_pipe[MEM_LAT-1]);

  // scoreboard: {ack_cycle[15:0], branch[2:0], idx[3:0], data[31:0]}
  logic [54:0] exp_q[$];
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // head model: an entry accepted in cycle T is popped in cycle T+1
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic [2:0]  pend_br;
  logic [3:0]  pend_idx;

  task automatic check_ack();
    logic [54:0] e;
    logic [15:0] e_cyc;
    if (mem_ack_vld) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(e[54:39]));
        check("ack_br", mem_ack_branch_id, e[38:36]);
        check("ack_idx", mem_ack_idx, e[35:32]);
        check("ack_data", mem_ack_data, e[31:0]);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q[0];
      e_cyc = e[54:39];
      if (64'(e_cyc) <= 64'(cyc)) begin
        check("ack_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // driver: one clock cycle of stimulus plus all per-cycle checks
  task automatic step(input logic vld, input logic [31:0] addr, input logic [2:0] br,
                      input logic [3:0] idx, input logic [2:0] cur);
    logic        exp_en;
    logic [31:0] exp_addr;
    @(posedge clk);
    #1;
    req_vld       = vld;
    req_addr      = addr;
    req_branch_id = br;
    req_idx       = idx;
    cur_branch_id = cur;
    exp_en   = pend_vld && (pend_br == cur) && (cur != 3'd0);
    exp_addr = pend_addr;
    if (exp_en) exp_q.push_back({16'(cyc + MEM_LAT), pend_br, pend_idx, sram_word(pend_addr)});
    @(negedge clk);
    check("req_rdy", req_rdy, 1);
    check("occupancy", occupancy, 64'(pend_vld));
    check("rd_en", mem_rd_en, exp_en);
    if (exp_en) check("rd_addr", mem_rd_addr, exp_addr);
    check_ack();
    pend_vld  = vld;
    pend_addr = addr;
    pend_br   = br;
    pend_idx  = idx;
  endtask

  task automatic idle(input int n, input logic [2:0] cur);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 3'd0, 4'd0, cur);
  endtask

  logic [2:0] cur_r, br_r;

  initial begin
    rst_n = 1'b0;
    req_vld = 1'b0; req_addr = '0; req_branch_id = '0; req_idx = '0; cur_branch_id = 3'd1;
    pend_vld = 1'b0; pend_addr = '0; pend_br = '0; pend_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_occupancy", occupancy, 0);
    check("rst_req_rdy", req_rdy, 1);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_ack_vld", mem_ack_vld, 0);
    check("rst_ack_br", mem_ack_branch_id, 0);
    check("rst_ack_idx", mem_ack_idx, 0);
    check("rst_ack_data", mem_ack_data, 0);
    rst_n = 1'b1;

    // single load: issue one cycle after accept, ack MEM_LAT later
    step(1'b1, 32'h100, 3'd1, 4'd3, 3'd1);
    idle(4, 3'd1);

    // back-to-back stream, one issue and one ack per cycle
    for (int k = 0; k < 6; k++) step(1'b1, 32'h200 + 32'(k * 4), 3'd1, 4'(k), 3'd1);
    idle(4, 3'd1);

    // stale epoch at pop: all three dropped
    step(1'b1, 32'h300, 3'd2, 4'd0, 3'd2);
    step(1'b1, 32'h304, 3'd2, 4'd1, 3'd3);
    step(1'b1, 32'h308, 3'd2, 4'd2, 3'd3);
    idle(4, 3'd3);

    // epoch 0 never matches, even against cur=0
    step(1'b1, 32'h400, 3'd0, 4'd9, 3'd0);
    idle(3, 3'd0);

    // epoch change after issue still acks with the old branch id
    step(1'b1, 32'h500, 3'd7, 4'd5, 3'd7);
    step(1'b0, 32'h0, 3'd0, 4'd0, 3'd7);
    idle(4, 3'd1);

    // sustained push/pop keeps occupancy steady across several pointer wraps
    for (int k = 0; k < 4 * DEPTH; k++) step(1'b1, 32'h600 + 32'(k), 3'd4, 4'(k), 3'd4);
    idle(4, 3'd4);

    // reset with one queued and two in flight: nothing survives
    step(1'b1, 32'h700, 3'd5, 4'd1, 3'd5);
    step(1'b1, 32'h704, 3'd5, 4'd2, 3'd5);
    step(1'b1, 32'h708, 3'd5, 4'd3, 3'd5);
    #2;
    rst_n = 1'b0;
    req_vld = 1'b0;
    #1;
    check("mid_rst_occupancy", occupancy, 0);
    check("mid_rst_ack_vld", mem_ack_vld, 0);
    check("mid_rst_rd_en", mem_rd_en, 0);
    check("mid_rst_ack_data", mem_ack_data, 0);
    exp_q.delete();
    pend_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_req_rdy", req_rdy, 1);
    check("post_rst_occupancy", occupancy, 0);
    idle(MEM_LAT + 3, 3'd5);

    // random traffic with occasional epoch changes
    cur_r = 3'd2;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 4) == 0) cur_r = 3'($urandom_range(0, 7));
      br_r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : cur_r;
      step(1'($urandom_range(0, 1)), $urandom, br_r, 4'($urandom_range(0, 15)), cur_r);
    end

    // bounded drain
    idle(MEM_LAT + 4, cur_r);
    check("drain_empty", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
